// File: rtl/mem_port_arbiter.sv
// Arbiter for the unified single-port memory shared by IF and MEM.
// Optional grant/conflict/squash counters: define MEM_ARB_STATS_EN.
module mem_port_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk1,
    input  logic          reset,
    input  logic          halt,
    input  logic          flush,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]   stat_if_grants,
    output logic [31:0]   stat_dm_grants,
    output logic [31:0]   stat_conflicts,
    output logic [31:0]   stat_squashed
`endif
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [SW-1:0]     starve_cnt;
    logic              starved;
    logic              if_ok;
    logic              rd_gnt;
    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_if;
    logic [DW-1:0]     if_hold;
    logic [DW-1:0]     dm_hold;

    assign starved = (starve_cnt == SW'(STARVE_MAX));
    // A fetch presented during a taken branch carries a stale address.
    assign if_ok   = if_req & ~flush;

    // Grant selection: data first unless fetch has waited too long.
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (!halt && !reset) begin
            priority case (1'b1)
                (dm_req && if_ok && starved): if_gnt = 1'b1;
                dm_req:                       dm_gnt = 1'b1;
                if_ok:                        if_gnt = 1'b1;
                default:                      ;
            endcase
        end
    end

    assign mem_en    = if_gnt | dm_gnt;
    assign mem_we    = dm_gnt & dm_we;
    assign mem_addr  = dm_gnt ? dm_addr : if_addr;
    assign mem_wdata = mem_we ? dm_wdata : '0;
    assign rd_gnt    = if_gnt | (dm_gnt & ~dm_we);

    // Count consecutive denied fetch cycles; halt and flush freeze it.
    always_ff @(posedge clk1) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (!flush && !halt && !starved) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Tag pipe tracks read owners; flush kills IF entries in flight.
    always_ff @(posedge clk1) begin
        if (reset) begin
            tag_v  <= '0;
            tag_if <= '0;
        end else begin
            tag_v[0]  <= rd_gnt;
            tag_if[0] <= if_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1] & ~(flush & tag_if[i-1]);
                tag_if[i] <= tag_if[i-1];
            end
        end
    end

    assign if_rvalid = tag_v[RD_LAT-1] & tag_if[RD_LAT-1];
    assign dm_rvalid = tag_v[RD_LAT-1] & ~tag_if[RD_LAT-1];

    // Remember the last delivered word so rdata holds between responses.
    always_ff @(posedge clk1) begin
        if (reset) begin
            if_hold <= '0;
            dm_hold <= '0;
        end else begin
            if (if_rvalid) if_hold <= mem_rdata;
            if (dm_rvalid) dm_hold <= mem_rdata;
        end
    end

    assign if_rdata = if_rvalid ? mem_rdata : if_hold;
    assign dm_rdata = dm_rvalid ? mem_rdata : dm_hold;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] sq_n;

    // IF reads still short of the output stage are lost on flush.
    always_comb begin
        sq_n = '0;
        if (flush) begin
            for (int i = 0; i < RD_LAT - 1; i++) begin
                sq_n = sq_n + 32'(tag_v[i] & tag_if[i]);
            end
        end
    end

    // Free-running statistics, frozen while the pipeline is halted.
    always_ff @(posedge clk1) begin
        if (reset) begin
            stat_if_grants <= '0;
            stat_dm_grants <= '0;
            stat_conflicts <= '0;
            stat_squashed  <= '0;
        end else if (!halt) begin
            stat_if_grants <= stat_if_grants + 32'(if_gnt);
            stat_dm_grants <= stat_dm_grants + 32'(dm_gnt);
            stat_conflicts <= stat_conflicts + 32'(dm_req & if_req);
            stat_squashed  <= stat_squashed + sq_n;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at read latency 1 (dut_a) and 3 (dut_b).
module tb_mem_port_arbiter;

    logic        clk1 = 1'b0;
    logic        reset = 1'b1;
    logic        halt = 1'b0;
    logic        flush = 1'b0;
    logic [9:0]  if_addr = '0;
    logic        dm_we = 1'b0;
    logic [9:0]  dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        a_if_req = 1'b0, a_dm_req = 1'b0;
    logic        b_if_req = 1'b0, b_dm_req = 1'b0;

    logic        a_if_gnt, a_if_rvalid, a_dm_gnt, a_dm_rvalid;
    logic        a_mem_en, a_mem_we;
    logic [31:0] a_if_rdata, a_dm_rdata, a_mem_wdata, a_mem_rdata;
    logic [9:0]  a_mem_addr;
    logic        b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_rvalid;
    logic        b_mem_en, b_mem_we;
    logic [31:0] b_if_rdata, b_dm_rdata, b_mem_wdata, b_mem_rdata;
    logic [9:0]  b_mem_addr;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] a_s0, a_s1, a_s2, a_s3, b_s0, b_s1, b_s2, b_s3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk1 = ~clk1;

    function automatic logic [31:0] f(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    logic [31:0] mem_a [1024];
    logic [31:0] rp_a;
    logic [31:0] mem_b [1024];
    logic [31:0] rp_b [3];

    // Latency-1 memory model for dut_a.
    always @(posedge clk1) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem_a[i] <= f(i);
        end else begin
            if (a_mem_en && a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
            if (a_mem_en && !a_mem_we) rp_a <= mem_a[a_mem_addr];
        end
    end
    assign a_mem_rdata = rp_a;

    // Latency-3 memory model for dut_b.
    always @(posedge clk1) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem_b[i] <= f(i);
        end else if (b_mem_en && b_mem_we) begin
            mem_b[b_mem_addr] <= b_mem_wdata;
        end
        rp_b[0] <= mem_b[b_mem_addr];
        rp_b[1] <= rp_b[0];
        rp_b[2] <= rp_b[1];
    end
    assign b_mem_rdata = rp_b[2];

    mem_port_arbiter #(.AW(10), .DW(32), .RD_LAT(1), .STARVE_MAX(3)) dut_a (
        .clk1(clk1), .reset(reset), .halt(halt), .flush(flush),
        .if_req(a_if_req), .if_addr(if_addr), .if_gnt(a_if_gnt),
        .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .dm_req(a_dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(a_dm_gnt),
        .dm_rvalid(a_dm_rvalid), .dm_rdata(a_dm_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
`ifdef MEM_ARB_STATS_EN
        , .stat_if_grants(a_s0), .stat_dm_grants(a_s1),
        .stat_conflicts(a_s2), .stat_squashed(a_s3)
`endif
    );

    mem_port_arbiter #(.AW(10), .DW(32), .RD_LAT(3), .STARVE_MAX(3)) dut_b (
        .clk1(clk1), .reset(reset), .halt(halt), .flush(flush),
        .if_req(b_if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .dm_req(b_dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(b_dm_gnt),
        .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
`ifdef MEM_ARB_STATS_EN
        , .stat_if_grants(b_s0), .stat_dm_grants(b_s1),
        .stat_conflicts(b_s2), .stat_squashed(b_s3)
`endif
    );

    task automatic tick();
        @(posedge clk1);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; a_if_req = 1'b1; a_dm_req = 1'b1;
        tick(); tick(); #1;
        checks++; if (a_if_gnt !== 1'b0) begin errors++; $display("FAIL rst_if_gnt got %b exp 0", a_if_gnt); end
        checks++; if (a_dm_gnt !== 1'b0) begin errors++; $display("FAIL rst_dm_gnt got %b exp 0", a_dm_gnt); end
        checks++; if (a_mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got %b exp 0", a_mem_en); end
        checks++; if (a_if_rvalid !== 1'b0) begin errors++; $display("FAIL rst_if_rvalid got %b exp 0", a_if_rvalid); end
        checks++; if (a_dm_rvalid !== 1'b0) begin errors++; $display("FAIL rst_dm_rvalid got %b exp 0", a_dm_rvalid); end
        checks++; if (a_if_rdata !== 32'h0) begin errors++; $display("FAIL rst_if_rdata got %h exp 0", a_if_rdata); end
        checks++; if (a_dm_rdata !== 32'h0) begin errors++; $display("FAIL rst_dm_rdata got %h exp 0", a_dm_rdata); end
        checks++; if (b_if_rvalid !== 1'b0) begin errors++; $display("FAIL rst_b_rvalid got %b exp 0", b_if_rvalid); end
        tick();
        reset = 1'b0; a_if_req = 1'b0; a_dm_req = 1'b0;
    endtask

    task automatic test_if_only();
        for (int k = 0; k < 4; k++) begin
            tick();
            a_if_req = 1'b1; if_addr = 10'(k);
            #1;
            checks++; if (a_if_gnt !== 1'b1) begin errors++; $display("FAIL ifo_gnt%0d got %b exp 1", k, a_if_gnt); end
            checks++; if (a_mem_we !== 1'b0) begin errors++; $display("FAIL ifo_we%0d got %b exp 0", k, a_mem_we); end
            checks++; if (a_mem_addr !== 10'(k)) begin errors++; $display("FAIL ifo_addr%0d got %h exp %h", k, a_mem_addr, k); end
            if (k == 0) begin
                checks++; if (a_if_rvalid !== 1'b0) begin errors++; $display("FAIL ifo_rv0 got %b exp 0", a_if_rvalid); end
            end else begin
                checks++; if (a_if_rvalid !== 1'b1) begin errors++; $display("FAIL ifo_rv%0d got %b exp 1", k, a_if_rvalid); end
                checks++; if (a_if_rdata !== f(k-1)) begin errors++; $display("FAIL ifo_rd%0d got %h exp %h", k, a_if_rdata, f(k-1)); end
            end
        end
        tick();
        a_if_req = 1'b0;
        #1;
        checks++; if (a_if_gnt !== 1'b0) begin errors++; $display("FAIL ifo_idle_gnt got %b exp 0", a_if_gnt); end
        checks++; if (a_if_rvalid !== 1'b1) begin errors++; $display("FAIL ifo_rv4 got %b exp 1", a_if_rvalid); end
        checks++; if (a_if_rdata !== f(3)) begin errors++; $display("FAIL ifo_rd4 got %h exp %h", a_if_rdata, f(3)); end
        tick(); #1;
        checks++; if (a_if_rvalid !== 1'b0) begin errors++; $display("FAIL ifo_rv5 got %b exp 0", a_if_rvalid); end
        checks++; if (a_if_rdata !== f(3)) begin errors++; $display("FAIL ifo_hold got %h exp %h", a_if_rdata, f(3)); end
    endtask

    task automatic test_conflict();
        tick();
        a_dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h20;
        a_if_req = 1'b1; if_addr = 10'd5;
        #1;
        checks++; if (a_dm_gnt !== 1'b1) begin errors++; $display("FAIL cf_dm_gnt got %b exp 1", a_dm_gnt); end
        checks++; if (a_if_gnt !== 1'b0) begin errors++; $display("FAIL cf_if_gnt0 got %b exp 0", a_if_gnt); end
        checks++; if (a_mem_addr !== 10'h20) begin errors++; $display("FAIL cf_addr got %h exp 020", a_mem_addr); end
        tick();
        a_dm_req = 1'b0;
        #1;
        checks++; if (a_if_gnt !== 1'b1) begin errors++; $display("FAIL cf_if_gnt1 got %b exp 1", a_if_gnt); end
        checks++; if (a_dm_rvalid !== 1'b1) begin errors++; $display("FAIL cf_dm_rv got %b exp 1", a_dm_rvalid); end
        checks++; if (a_dm_rdata !== f(32'h20)) begin errors++; $display("FAIL cf_dm_rd got %h exp %h", a_dm_rdata, f(32'h20)); end
        checks++; if (a_if_rvalid !== 1'b0) begin errors++; $display("FAIL cf_if_rv1 got %b exp 0", a_if_rvalid); end
        tick();
        a_if_req = 1'b0;
        #1;
        checks++; if (a_if_rvalid !== 1'b1) begin errors++; $display("FAIL cf_if_rv2 got %b exp 1", a_if_rvalid); end
        checks++; if (a_if_rdata !== f(5)) begin errors++; $display("FAIL cf_if_rd got %h exp %h", a_if_rdata, f(5)); end
        checks++; if (a_dm_rvalid !== 1'b0) begin errors++; $display("FAIL cf_dm_rv2 got %b exp 0", a_dm_rvalid); end
    endtask

    task automatic test_starvation();
        logic exp_if;
        for (int k = 0; k < 6; k++) begin
            tick();
            a_dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h30;
            a_if_req = 1'b1; if_addr = 10'd7;
            #1;
            exp_if = (k == 3);
            checks++; if (a_if_gnt !== exp_if) begin errors++; $display("FAIL sv_if_gnt%0d got %b exp %b", k, a_if_gnt, exp_if); end
            checks++; if (a_dm_gnt !== !exp_if) begin errors++; $display("FAIL sv_dm_gnt%0d got %b exp %b", k, a_dm_gnt, !exp_if); end
            if (k == 4) begin
                checks++; if (a_if_rvalid !== 1'b1 || a_if_rdata !== f(7)) begin errors++; $display("FAIL sv_if_resp got %b/%h exp 1/%h", a_if_rvalid, a_if_rdata, f(7)); end
            end
        end
        tick();
        a_dm_req = 1'b0; a_if_req = 1'b0;
        #1;
        checks++; if (a_dm_rvalid !== 1'b1 || a_dm_rdata !== f(32'h30)) begin errors++; $display("FAIL sv_dm_resp got %b/%h exp 1/%h", a_dm_rvalid, a_dm_rdata, f(32'h30)); end
    endtask

    task automatic test_store();
        tick();
        a_dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h10; dm_wdata = 32'hDEADBEEF;
        #1;
        checks++; if (a_dm_gnt !== 1'b1) begin errors++; $display("FAIL st_gnt got %b exp 1", a_dm_gnt); end
        checks++; if (a_mem_we !== 1'b1) begin errors++; $display("FAIL st_we got %b exp 1", a_mem_we); end
        checks++; if (a_mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL st_wdata got %h exp deadbeef", a_mem_wdata); end
        checks++; if (a_mem_addr !== 10'h10) begin errors++; $display("FAIL st_addr got %h exp 010", a_mem_addr); end
        tick();
        dm_we = 1'b0;
        #1;
        checks++; if (a_mem_we !== 1'b0) begin errors++; $display("FAIL ld_we got %b exp 0", a_mem_we); end
        checks++; if (a_mem_wdata !== 32'h0) begin errors++; $display("FAIL ld_wdata got %h exp 0", a_mem_wdata); end
        checks++; if (a_dm_rvalid !== 1'b0) begin errors++; $display("FAIL st_no_resp got %b exp 0", a_dm_rvalid); end
        tick();
        a_dm_req = 1'b0;
        #1;
        checks++; if (a_mem_en !== 1'b0) begin errors++; $display("FAIL st_idle_en got %b exp 0", a_mem_en); end
        checks++; if (a_dm_rvalid !== 1'b1 || a_dm_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_resp got %b/%h exp 1/deadbeef", a_dm_rvalid, a_dm_rdata); end
    endtask

    task automatic test_halt();
        tick();
        b_if_req = 1'b1; if_addr = 10'd2;
        #1;
        checks++; if (b_if_gnt !== 1'b1) begin errors++; $display("FAIL ht_gnt0 got %b exp 1", b_if_gnt); end
        tick();
        halt = 1'b1; if_addr = 10'd3; b_dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h21;
        #1;
        checks++; if (b_if_gnt !== 1'b0 || b_dm_gnt !== 1'b0) begin errors++; $display("FAIL ht_nogrant1 got %b%b exp 00", b_if_gnt, b_dm_gnt); end
        checks++; if (b_mem_en !== 1'b0) begin errors++; $display("FAIL ht_en got %b exp 0", b_mem_en); end
        tick(); #1;
        checks++; if (b_if_gnt !== 1'b0 || b_dm_gnt !== 1'b0) begin errors++; $display("FAIL ht_nogrant2 got %b%b exp 00", b_if_gnt, b_dm_gnt); end
        tick(); #1;
        checks++; if (b_if_rvalid !== 1'b1 || b_if_rdata !== f(2)) begin errors++; $display("FAIL ht_inflight got %b/%h exp 1/%h", b_if_rvalid, b_if_rdata, f(2)); end
        checks++; if (b_dm_gnt !== 1'b0) begin errors++; $display("FAIL ht_nogrant3 got %b exp 0", b_dm_gnt); end
        tick();
        halt = 1'b0; b_dm_req = 1'b0;
        #1;
        checks++; if (b_if_gnt !== 1'b1) begin errors++; $display("FAIL ht_resume got %b exp 1", b_if_gnt); end
        checks++; if (b_if_rvalid !== 1'b0) begin errors++; $display("FAIL ht_rv_off got %b exp 0", b_if_rvalid); end
        tick();
        b_if_req = 1'b0;
        tick();
        tick(); #1;
        checks++; if (b_if_rvalid !== 1'b1 || b_if_rdata !== f(3)) begin errors++; $display("FAIL ht_resume_resp got %b/%h exp 1/%h", b_if_rvalid, b_if_rdata, f(3)); end
    endtask

    task automatic test_flush();
        tick();
        b_if_req = 1'b1; if_addr = 10'd8;
        #1;
        checks++; if (b_if_gnt !== 1'b1) begin errors++; $display("FAIL fl_gnt8 got %b exp 1", b_if_gnt); end
        tick();
        if_addr = 10'd9;
        #1;
        checks++; if (b_if_gnt !== 1'b1) begin errors++; $display("FAIL fl_gnt9 got %b exp 1", b_if_gnt); end
        tick();
        flush = 1'b1; if_addr = 10'd10; b_dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h22;
        #1;
        checks++; if (b_dm_gnt !== 1'b1 || b_if_gnt !== 1'b0) begin errors++; $display("FAIL fl_c2_gnt got dm%b if%b exp dm1 if0", b_dm_gnt, b_if_gnt); end
        tick();
        b_dm_req = 1'b0;
        #1;
        checks++; if (b_if_gnt !== 1'b0) begin errors++; $display("FAIL fl_same_cycle got %b exp 0", b_if_gnt); end
        checks++; if (b_if_rvalid !== 1'b0) begin errors++; $display("FAIL fl_sq8 got %b exp 0", b_if_rvalid); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if (b_if_gnt !== 1'b1) begin errors++; $display("FAIL fl_gnt10 got %b exp 1", b_if_gnt); end
        checks++; if (b_if_rvalid !== 1'b0) begin errors++; $display("FAIL fl_sq9 got %b exp 0", b_if_rvalid); end
        tick();
        b_if_req = 1'b0;
        #1;
        checks++; if (b_dm_rvalid !== 1'b1 || b_dm_rdata !== f(32'h22)) begin errors++; $display("FAIL fl_dm_resp got %b/%h exp 1/%h", b_dm_rvalid, b_dm_rdata, f(32'h22)); end
        checks++; if (b_if_rvalid !== 1'b0) begin errors++; $display("FAIL fl_rv5 got %b exp 0", b_if_rvalid); end
        tick(); #1;
        checks++; if (b_if_rvalid !== 1'b0) begin errors++; $display("FAIL fl_rv6 got %b exp 0", b_if_rvalid); end
        tick(); #1;
        checks++; if (b_if_rvalid !== 1'b1 || b_if_rdata !== f(10)) begin errors++; $display("FAIL fl_resp10 got %b/%h exp 1/%h", b_if_rvalid, b_if_rdata, f(10)); end
    endtask

    task automatic test_reset_mid();
        tick();
        b_if_req = 1'b1; if_addr = 10'd4;
        #1;
        checks++; if (b_if_gnt !== 1'b1) begin errors++; $display("FAIL rm_if_gnt got %b exp 1", b_if_gnt); end
        tick();
        b_if_req = 1'b0; b_dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h21;
        #1;
        checks++; if (b_dm_gnt !== 1'b1) begin errors++; $display("FAIL rm_dm_gnt got %b exp 1", b_dm_gnt); end
        tick();
        reset = 1'b1; b_dm_req = 1'b0; b_if_req = 1'b1;
        #1;
        checks++; if (b_if_gnt !== 1'b0) begin errors++; $display("FAIL rm_gnt_in_reset got %b exp 0", b_if_gnt); end
        tick();
        reset = 1'b0; b_if_req = 1'b0;
        #1;
        checks++; if (b_if_rvalid !== 1'b0) begin errors++; $display("FAIL rm_if_rv got %b exp 0", b_if_rvalid); end
        checks++; if (b_if_rdata !== 32'h0) begin errors++; $display("FAIL rm_if_rd got %h exp 0", b_if_rdata); end
        checks++; if (a_if_rdata !== 32'h0) begin errors++; $display("FAIL rm_a_if_rd got %h exp 0", a_if_rdata); end
        checks++; if (a_dm_rdata !== 32'h0) begin errors++; $display("FAIL rm_a_dm_rd got %h exp 0", a_dm_rdata); end
        tick(); #1;
        checks++; if (b_dm_rvalid !== 1'b0) begin errors++; $display("FAIL rm_dm_rv got %b exp 0", b_dm_rvalid); end
        checks++; if (b_dm_rdata !== 32'h0) begin errors++; $display("FAIL rm_dm_rd got %h exp 0", b_dm_rdata); end
    endtask

    initial begin
        test_reset();
        test_if_only();
        test_conflict();
        test_starvation();
        test_store();
        test_halt();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
